// File: rtl/pixel_sched_pkg.sv
// Shared types for the pixel write scheduler.
//   pixel_t       : one queued brush point {x, y, color}
//   FB_AW         : framebuffer address width ({y, x})
//   sched_state_t : scheduler FSM states
package pixel_sched_pkg;

  localparam int unsigned FB_AW = 16;
  localparam int unsigned CW_W  = 3;

  typedef struct packed {
    logic [7:0]      x;
    logic [7:0]      y;
    logic [CW_W-1:0] color;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } sched_state_t;

endpackage

// File: rtl/pixel_write_sched_fifo.sv
// pixel_fifo: synchronous FIFO of pixel_t brush points.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   push, wdata  : enqueue request and data (dropped when full unless popping)
//   pop          : dequeue head (ignored when empty)
//   rdata        : head entry, valid while !empty
//   full, empty  : status from registered pointers
//   count        : number of stored entries
module pixel_fifo
  import pixel_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  pixel_t                   wdata,
  input  logic                     pop,
  output pixel_t                   rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  pixel_t         mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A pop frees the head slot in the same cycle, so a push into a full queue is accepted.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is data-only and needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pixel_write_sched.sv
// pixel_write_sched: shares one framebuffer port between display reads and
// queued brush writes (plus an optional full-framebuffer clear).
// Ports:
//   clk, reset            : clock, async active-low reset
//   brushUpdate, x, y,    : enqueue a brush point (pulse)
//   color
//   clearReq              : start a clear of all 64K pixels (pulse)
//   vidRd, vidAddr        : display read request, owns the port that cycle
//   fbWe, fbAddr, fbWData : framebuffer port (combinational from state)
//   busy                  : queue non-empty or clear running
//   overflow              : sticky, a brush point was dropped
// Build option: define PIXEL_SCHED_CLEAR_EN to include the clear sequencer;
// without it clearReq is ignored and overflow clears only on reset.
module pixel_write_sched
  import pixel_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [2:0]  CLEAR_COLOR = 3'b000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             brushUpdate,
  input  logic [7:0]       x,
  input  logic [7:0]       y,
  input  logic [2:0]       color,
  input  logic             clearReq,
  input  logic             vidRd,
  input  logic [FB_AW-1:0] vidAddr,
  output logic             fbWe,
  output logic [FB_AW-1:0] fbAddr,
  output logic [2:0]       fbWData,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  sched_state_t  state;
  sched_state_t  state_next;
  pixel_t        wr_pix;
  pixel_t        head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic          empty_next;
  logic          clear_acc;

  assign wr_pix = '{x: x, y: y, color: color};

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (brushUpdate),
    .wdata (wr_pix),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign push_ok    = brushUpdate && (!full || pop);
  assign drop       = brushUpdate && full && !pop;
  assign count_next = count + CW'(push_ok) - CW'(pop);
  assign empty_next = (count_next == '0);

`ifdef PIXEL_SCHED_CLEAR_EN
  logic [FB_AW-1:0] clear_cnt;

  // A request arriving mid-clear is ignored rather than restarting the sweep.
  assign clear_acc = clearReq && (state != CLEAR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clear_cnt <= '0;
    end else if (clear_acc) begin
      clear_cnt <= '0;
    end else if ((state == CLEAR) && fbWe) begin
      clear_cnt <= clear_cnt + FB_AW'(1);
    end
  end
`else
  logic       unused_clear_req;
  logic [2:0] unused_clear_color;
  assign clear_acc          = 1'b0;
  assign unused_clear_req   = clearReq;
  assign unused_clear_color = CLEAR_COLOR;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and port arbitration; display reads always win the port.
  always_comb begin
    state_next = state;
    fbWe       = 1'b0;
    fbAddr     = vidAddr;
    fbWData    = '0;
    pop        = 1'b0;
    case (state)
      IDLE, DRAIN: begin
        // IDLE also writes a pending head so a fresh point lands one cycle after its push.
        if (!vidRd && !empty) begin
          fbWe    = 1'b1;
          fbAddr  = {head.y, head.x};
          fbWData = head.color;
          pop     = 1'b1;
        end
        if (clear_acc)       state_next = CLEAR;
        else if (empty_next) state_next = IDLE;
        else                 state_next = DRAIN;
      end
`ifdef PIXEL_SCHED_CLEAR_EN
      CLEAR: begin
        if (!vidRd) begin
          fbWe    = 1'b1;
          fbAddr  = clear_cnt;
          fbWData = CLEAR_COLOR;
          if (clear_cnt == '1) state_next = empty_next ? IDLE : DRAIN;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign busy = !empty || (state == CLEAR);

  // Sticky drop flag; a drop in the same cycle as a clear acceptance still sets it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else begin
      if (clear_acc) overflow <= 1'b0;
      if (drop)      overflow <= 1'b1;
    end
  end

endmodule

// File: doc/pixel_write_sched.md
PIXEL_WRITE_SCHED -- requirements
Module: pixel_write_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, brush-point queue depth (power of 2, >=2).
REQ-002 SHALL have parameter CLEAR_COLOR, default 3'b000, colour written by the clear sequence.
REQ-003 SHALL have port clk  in  1  single system clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port brushUpdate  in  1  one-cycle pulse: x/y/color valid, enqueue point.
REQ-006 SHALL have ports x, y  in  8 each  brush pixel coordinates.
REQ-007 SHALL have port color  in  3  brush pixel colour.
REQ-008 SHALL have port clearReq  in  1  one-cycle pulse: start full-framebuffer clear.
REQ-009 SHALL have port vidRd  in  1  display read request; owns the port that cycle.
REQ-010 SHALL have port vidAddr  in  16  display read address.
REQ-011 SHALL have port fbWe  out  1  framebuffer write enable.
REQ-012 SHALL have port fbAddr  out  16  framebuffer address.
REQ-013 SHALL have port fbWData  out  3  framebuffer write data.
REQ-014 SHALL have port busy  out  1  high when queue non-empty or clear in progress.
REQ-015 SHALL have port overflow  out  1  sticky: a brush point was dropped.

Function
REQ-016 SHALL arbitrate one framebuffer port: vidRd=1 -> fbAddr=vidAddr, fbWe=0, no write issued that cycle.
REQ-017 SHALL, when vidRd=0 and a write is pending, drive fbWe=1 combinationally from registered state; fbAddr/fbWData per REQ-019/020.
REQ-018 SHALL implement states IDLE, DRAIN, CLEAR; IDLE->CLEAR on clearReq; IDLE->DRAIN when queue non-empty; DRAIN->IDLE when last entry popped; CLEAR->DRAIN (queue non-empty) or IDLE (empty) after address 16'hFFFF written.
REQ-019 SHALL, in DRAIN, write head entry: fbAddr={y,x}, fbWData=color; pop only in a cycle with fbWe=1.
REQ-020 SHALL, in CLEAR, write CLEAR_COLOR to fbAddr=clearCnt, incrementing clearCnt only when fbWe=1; clearCnt starts at 0.
REQ-021 SHALL give clearReq priority over DRAIN: clearReq in DRAIN -> CLEAR next cycle, queue retained.
REQ-022 SHALL ignore clearReq while in CLEAR (no restart).
REQ-023 SHALL keep enqueueing brushUpdate in every state; latency push (cycle N) -> earliest fbWe for that point is N+1 when IDLE, queue empty, vidRd=0.
REQ-024 SHALL drop brushUpdate when queue full and no pop that cycle; push with simultaneous pop while full SHALL be accepted.
REQ-025 SHALL set overflow on a dropped push; clear it only on reset or accepted clearReq.
REQ-026 SHALL drive fbWe=0 and fbAddr=vidAddr in IDLE with no pending work.
REQ-027 SHALL wrap FIFO pointers modulo FIFO_DEPTH using one extra bit for full/empty distinction.

Reset
REQ-028 SHALL on reset=0 asynchronously force state IDLE, queue empty, clearCnt=0, overflow=0, fbWe=0, busy=0.
REQ-029 SHALL abandon an in-progress clear or drain on reset; no partial write after reset asserts.

Configuration
REQ-030 SHALL compile the clear sequencer only when macro PIXEL_SCHED_CLEAR_EN is defined.
REQ-031 SHALL, without PIXEL_SCHED_CLEAR_EN, omit CLEAR state and clearCnt, ignore clearReq, and clear overflow only on reset.

Structure
REQ-032 SHALL place pixel_t struct {x,y,color}, FB_AW=16, and sched_state_t enum in shared package pixel_sched_pkg.
REQ-033 SHALL instantiate one sub-module pixel_fifo (sync FIFO of pixel_t, push/pop/full/empty).

Verification
REQ-034 SHALL test: brushUpdate x=8'h12,y=8'h34,color=3'd5, vidRd=0 -> next cycle fbWe=1, fbAddr=16'h3412, fbWData=5, busy falls after.
REQ-035 SHALL test: same push with vidRd=1 for 3 cycles -> fbWe=0, fbAddr=vidAddr for 3 cycles, write on 4th.
REQ-036 SHALL test: 5 pushes in 5 consecutive cycles, vidRd=1 throughout, depth 4 -> 4 retained, overflow=1, 4 writes after vidRd drops.
REQ-037 SHALL test: clearReq with 2 queued points -> 65536 writes of CLEAR_COLOR to 0..FFFF, then the 2 points written, overflow=0.
REQ-038 SHALL test: reset=0 mid-clear at clearCnt=16'h0100 -> immediate fbWe=0, busy=0; after release IDLE, no writes.
REQ-039 SHALL test: build without PIXEL_SCHED_CLEAR_EN, pulse clearReq -> no writes, overflow unchanged.
